seq_stim_gen: RTL and testbench
===============================

SEQ_STIM_GEN -- requirements
Module: seq_stim_gen

Interface
REQ-001 Parameter WIDTH, default 16, maximum pattern length in bits.
REQ-002 Parameter RUN, default 4, run length of equal consecutive bits that asserts ZExp.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Load  input  1  capture Pattern and Len (accepted only when Busy=0).
REQ-006 Pattern  input  WIDTH  bit sequence, transmitted MSB first.
REQ-007 Len  input  clog2(WIDTH+1)  number of bits to transmit, valid range 1..WIDTH.
REQ-008 Start  input  1  begin transmission (accepted only when Busy=0).
REQ-009 Stop  input  1  abort transmission.
REQ-010 Tick  input  1  bit-rate enable; one bit emitted per Tick while shifting.
REQ-011 Repeat  input  1  sampled at end of sequence; 1 = restart sequence without gap.
REQ-012 W  output  1  serial stimulus bit, held between Ticks.
REQ-013 Valid  output  1  one-cycle pulse coincident with each new W value.
REQ-014 Busy  output  1  high while in SHIFT state.
REQ-015 Done  output  1  one-cycle pulse after last bit of a non-repeating sequence.
REQ-016 ZExp  output  1  expected detector output: high while the last RUN emitted bits are equal.

Function
REQ-017 States: IDLE, SHIFT; Busy = (state == SHIFT).
REQ-018 IDLE + Load: PatReg <= Pattern, LenReg <= Len, ShReg <= Pattern; Load ignored in SHIFT.
REQ-019 IDLE + Start with effective length != 0 -> SHIFT next cycle; BitCnt <= 0, run counter <= 0, ShReg <= PatReg.
REQ-020 Load and Start in the same IDLE cycle: Start uses the newly presented Pattern/Len.
REQ-021 Start with effective length 0 or Len > WIDTH: ignored, remain IDLE, no Done.
REQ-022 Tick in the cycle Start is accepted is ignored; first bit emitted on first Tick sampled in SHIFT.
REQ-023 SHIFT + Tick: next cycle W <= ShReg[WIDTH-1], Valid = 1, ShReg shifts left by 1, BitCnt increments.
REQ-024 Latency: W/Valid/ZExp update exactly one cycle after the Tick is sampled.
REQ-025 Last bit (BitCnt == LenReg-1 on Tick) with Repeat=1: ShReg <= PatReg, BitCnt <= 0, stay SHIFT; next Tick emits Pattern MSB; no Done.
REQ-026 Last bit with Repeat=0: -> IDLE, Done = 1 in the same cycle as the final Valid.
REQ-027 Run counter saturates at RUN: new bit equal to W -> min(run+1, RUN), else 1; first bit after Start -> 1.
REQ-028 ZExp = (run == RUN), registered with W; continues across Repeat wrap; held when no Tick.
REQ-029 Stop in SHIFT: -> IDLE next cycle, no Valid, no Done; Stop beats a simultaneous Tick; W and ZExp keep last values.
REQ-030 Stop in IDLE: no effect.
REQ-031 Valid and Done are never high for more than one consecutive cycle per event.

Reset
REQ-032 Reset has priority over all inputs: state IDLE, W=0, Valid=0, Busy=0, Done=0, ZExp=0, run=0, BitCnt=0, PatReg=0, ShReg=0, LenReg=0.
REQ-033 Reset asserted mid-SHIFT aborts immediately; no Done, no Valid in the reset cycle or after it until a new Start.

Verification
REQ-034 Load 16'hF0F0, Len=8, Start, 8 Ticks, Repeat=0 -> W = 1,1,1,1,0,0,0,0; ZExp high after bits 4 and 8 only; Done with bit 8; Busy low the cycle after.
REQ-035 Load 16'hA000, Len=3, Repeat=1, 9 Ticks -> W = 101 101 101; ZExp never high; no Done; Busy stays 1.
REQ-036 Load 16'h0000, Len=16, Start, 6 Ticks, Stop together with Tick 7 -> 6 Valids, ZExp high from bit 4, no 7th Valid, IDLE, no Done.
REQ-037 Start with Len=0, and Load while Busy -> no state change; PatReg unchanged.
REQ-038 Reset asserted after 3rd bit of 16'hFFFF/Len=16 -> all outputs 0 next cycle; new Start replays from MSB with run restarted.
REQ-039 Ticks spaced 1, 3 and 7 cycles apart -> exactly one Valid per Tick, W stable between Ticks.

Source files
------------

// File: rtl/seq_stim_gen.sv
// seq_stim_gen: serial stimulus generator. Shifts a loaded pattern out MSB
// first, one bit per Tick, and produces the expected output of a run-length
// detector (ZExp) alongside each emitted bit.
module seq_stim_gen #(
    parameter int WIDTH = 16,
    parameter int RUN   = 4,
    localparam int LW   = $clog2(WIDTH + 1),
    localparam int RW   = $clog2(RUN + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [LW-1:0]    Len,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Tick,
    input  logic             Repeat,
    output logic             W,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic             ZExp
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [RW-1:0] RUN_L   = RW'(RUN);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    run_q, run_d;
    logic             w_q, w_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             zexp_q, zexp_d;

    // Start sees the pattern/length presented this cycle when Load coincides.
    logic [WIDTH-1:0] eff_pat;
    logic [LW-1:0]    eff_len;
    logic             new_bit;
    logic [RW-1:0]    new_run;

    // Next-state and output computation for the IDLE/SHIFT machine.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        w_d     = w_q;
        zexp_d  = zexp_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        eff_pat = Load ? Pattern : pat_q;
        eff_len = Load ? Len : len_q;
        new_bit = sh_q[WIDTH-1];
        new_run = run_q;

        case (state_q)
            IDLE: begin
                if (Load) begin
                    pat_d = Pattern;
                    len_d = Len;
                    sh_d  = Pattern;
                end
                // Zero or oversize lengths leave the machine idle.
                if (Start && (eff_len != '0) && (eff_len <= WIDTH_L)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    run_d   = '0;
                    sh_d    = eff_pat;
                end
            end
            SHIFT: begin
                if (Stop) begin
                    // Abort wins over a simultaneous Tick; W/ZExp keep last values.
                    state_d = IDLE;
                end else if (Tick) begin
                    // run_q == 0 only right after Start: first bit opens a run of 1.
                    if (run_q == '0)
                        new_run = RW'(1);
                    else if (new_bit == w_q)
                        new_run = (run_q == RUN_L) ? RUN_L : run_q + RW'(1);
                    else
                        new_run = RW'(1);
                    run_d   = new_run;
                    w_d     = new_bit;
                    zexp_d  = (new_run == RUN_L);
                    valid_d = 1'b1;
                    if (cnt_q == len_q - LW'(1)) begin
                        if (Repeat) begin
                            sh_d  = pat_q;
                            cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        sh_d  = sh_q << 1;
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset overrides every input.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            zexp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            zexp_q  <= zexp_d;
        end
    end

    assign W     = w_q;
    assign Valid = valid_q;
    assign Done  = done_q;
    assign ZExp  = zexp_q;
    assign Busy  = (state_q == SHIFT);

endmodule

// File: tb/tb_seq_stim_gen.sv
// Bench for seq_stim_gen: a transaction model predicts each emitted bit when
// its Tick is driven; a negedge monitor pops and compares on every Valid.
module tb_seq_stim_gen;

    localparam int WD   = 16;
    localparam int RUNL = 4;
    localparam int LW   = $clog2(WD + 1);

    logic          clk = 1'b0;
    logic          Reset, Load, Start, Stop, Tick, Repeat;
    logic [WD-1:0] Pattern;
    logic [LW-1:0] Len;
    logic          W, Valid, Busy, Done, ZExp;

    always #5 clk = ~clk;

    seq_stim_gen #(.WIDTH(WD), .RUN(RUNL)) dut (
        .Clock(clk), .Reset(Reset), .Load(Load), .Pattern(Pattern), .Len(Len),
        .Start(Start), .Stop(Stop), .Tick(Tick), .Repeat(Repeat),
        .W(W), .Valid(Valid), .Busy(Busy), .Done(Done), .ZExp(ZExp)
    );

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard entries: {w, zexp, done}
    logic [2:0] exp_q[$];

    // Reference model state
    logic [WD-1:0] m_pat;
    int            m_len;
    bit            m_busy;
    int            m_idx;
    int            m_run;
    logic          m_w;

    // Monitor state
    logic          hold_w, hold_z;
    logic [31:0]   got_w, got_z;
    int            nvalid;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_w  = '0;
        got_z  = '0;
        nvalid = 0;
    endtask

    task automatic model_tick(input bit rep);
        logic b;
        bit   last;
        if (m_busy) begin
            b = m_pat[WD-1-m_idx];
            if (m_run == 0)    m_run = 1;
            else if (b == m_w) m_run = (m_run < RUNL) ? m_run + 1 : RUNL;
            else               m_run = 1;
            m_w  = b;
            last = (m_idx == m_len - 1);
            exp_q.push_back({b, (m_run == RUNL), (last && !rep)});
            if (last) begin
                if (rep) m_idx = 0;
                else     m_busy = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic do_tick(input bit rep);
        Tick = 1'b1; Repeat = rep;
        model_tick(rep);
        step();
        Tick = 1'b0; Repeat = 1'b0;
    endtask

    task automatic do_start(input logic [WD-1:0] pat, input int len, input bit ld, input bit tk);
        Load = ld; Pattern = pat; Len = LW'(len); Start = 1'b1; Tick = tk;
        if (!m_busy) begin
            if (ld) begin m_pat = pat; m_len = len; end
            if (m_len != 0 && m_len <= WD) begin
                m_busy = 1; m_idx = 0; m_run = 0;
            end
        end
        step();
        Load = 1'b0; Start = 1'b0; Tick = 1'b0;
    endtask

    task automatic do_load(input logic [WD-1:0] pat, input int len);
        Load = 1'b1; Pattern = pat; Len = LW'(len);
        if (!m_busy) begin m_pat = pat; m_len = len; end
        step();
        Load = 1'b0;
    endtask

    task automatic do_stop(input bit tk);
        Stop = 1'b1; Tick = tk;
        m_busy = 0;
        step();
        Stop = 1'b0; Tick = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        exp_q.delete();
        m_pat = '0; m_len = 0; m_busy = 0; m_run = 0; m_w = 1'b0; m_idx = 0;
        hold_w = 1'b0; hold_z = 1'b0;
        Reset = 1'b0;
        chk("reset_outputs", {27'd0, W, Valid, Busy, Done, ZExp}, 32'd0);
    endtask

    // Compare each emitted bit against the scoreboard; check holds otherwise.
    always @(negedge clk) begin
        logic [2:0] e;
        if (Valid) begin
            got_w = {got_w[30:0], W};
            got_z = {got_z[30:0], ZExp};
            nvalid++;
            if (exp_q.size() == 0) begin
                chk("extra_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("w", {31'd0, W}, {31'd0, e[2]});
                chk("zexp", {31'd0, ZExp}, {31'd0, e[1]});
                chk("done", {31'd0, Done}, {31'd0, e[0]});
            end
            hold_w = W;
            hold_z = ZExp;
        end else begin
            if (Done) chk("done_wo_valid", 32'd1, 32'd0);
            chk("w_hold", {31'd0, W}, {31'd0, hold_w});
            chk("zexp_hold", {31'd0, ZExp}, {31'd0, hold_z});
        end
    end

    initial begin
        Reset = 1'b0; Load = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
        Repeat = 1'b0; Pattern = '0; Len = '0;
        hold_w = 1'b0; hold_z = 1'b0;
        clear_got();
        @(negedge clk);
        Reset = 1'b1;
        do_reset();

        // F0F0 / 8 bits, non-repeating; Tick with Start is ignored
        clear_got();
        do_start(16'hF0F0, 8, 1, 1);
        chk("s1_busy", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < 8; i++) do_tick(0);
        chk("s1_done_pulse", {31'd0, Done}, 32'd1);
        chk("s1_busy_end", {31'd0, Busy}, 32'd0);
        step();
        chk("s1_done_once", {31'd0, Done}, 32'd0);
        chk("s1_bits", got_w[7:0], 32'h0000_00F0);
        chk("s1_zexp", got_z[7:0], 32'h0000_0011);
        chk("s1_count", nvalid, 8);

        // A000 / 3 bits with Repeat: 101 101 101
        clear_got();
        do_start(16'hA000, 3, 1, 0);
        for (int i = 0; i < 9; i++) do_tick(1);
        step();
        chk("s2_bits", got_w[8:0], 32'h0000_016D);
        chk("s2_zexp", got_z[8:0], 32'd0);
        chk("s2_busy", {31'd0, Busy}, 32'd1);
        do_stop(0);
        chk("s2_stopped", {31'd0, Busy}, 32'd0);

        // All-zero / 16 bits: Stop together with Tick 7
        clear_got();
        do_start(16'h0000, 16, 1, 0);
        for (int i = 0; i < 6; i++) do_tick(0);
        do_stop(1);
        chk("s3_idle", {31'd0, Busy}, 32'd0);
        step(); step();
        chk("s3_count", nvalid, 6);
        chk("s3_zexp", got_z[5:0], 32'h0000_0007);
        chk("s3_q_empty", exp_q.size(), 0);

        // Len 0 and Len > WIDTH are ignored; Load while busy is ignored
        do_start(16'h1234, 0, 1, 0);
        chk("s4_len0", {31'd0, Busy}, 32'd0);
        do_start(16'h1234, 17, 1, 0);
        chk("s4_len17", {31'd0, Busy}, 32'd0);
        do_start(16'hC000, 4, 1, 0);
        chk("s4_started", {31'd0, Busy}, 32'd1);
        do_load(16'h3FFF, 4);
        for (int i = 0; i < 4; i++) do_tick(0);
        step();
        clear_got();
        do_start(16'h0000, 0, 0, 0);
        chk("s4_restart", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < 4; i++) do_tick(0);
        step();
        chk("s4_bits", got_w[3:0], 32'h0000_000C);

        // Reset after third bit of FFFF, then replay from MSB
        clear_got();
        do_start(16'hFFFF, 16, 1, 0);
        for (int i = 0; i < 3; i++) do_tick(0);
        do_reset();
        clear_got();
        do_start(16'hFFFF, 16, 1, 0);
        for (int i = 0; i < 4; i++) do_tick(0);
        step();
        chk("s5_bits", got_w[3:0], 32'h0000_000F);
        chk("s5_zexp", got_z[3:0], 32'h0000_0001);
        do_stop(0);

        // Ticks spaced 1, 3 and 7 cycles apart
        clear_got();
        do_start(16'h9A5C, 16, 1, 0);
        do_tick(0);
        do_tick(0);
        repeat (2) step();
        do_tick(0);
        repeat (6) step();
        do_tick(0);
        do_tick(0);
        repeat (2) step();
        do_tick(0);
        step();
        chk("s6_count", nvalid, 6);
        chk("s6_bits", got_w[5:0], 32'h0000_0026);
        do_stop(0);
        step();

        chk("final_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
